// File: rtl/zelda_sprite_pkg.sv
// Shared types and constants for the player-sprite fetch path.
// Imported by the animation controller and the per-pixel fetch front end.
package zelda_sprite_pkg;

   typedef enum logic [1:0] {
      DIR_DOWN  = 2'd0,
      DIR_UP    = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic {
      ANIM_IDLE = 1'b0,
      ANIM_WALK = 1'b1
   } anim_state_t;

   localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

   localparam int DEF_SPRITE_W = 16;
   localparam int DEF_SPRITE_H = 16;

   // Width of a counter over n values, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Walk-animation FSM plus the per-frame direction latch.
// Only frame_tick cycles change any state held here.
module sprite_anim_ctrl
   import zelda_sprite_pkg::*;
#(
   parameter int FRAMES   = 2,
   parameter int ANIM_DIV = 8,
   parameter int FW       = clog2_min1(FRAMES),
   parameter int CW       = clog2_min1(ANIM_DIV)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_tick,
   input  logic [1:0]    dir_in,
   input  logic          moving,
   output dir_t          dir_out,
   output logic [FW-1:0] anim_frame
);

   anim_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] frame_q, frame_d;
   dir_t          dir_q, dir_d;
   logic          dir_chg;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      dir_d   = dir_q;
      dir_chg = 1'b0;
      if (frame_tick) begin
         dir_d   = dir_t'(dir_in);
         dir_chg = (dir_d != dir_q);
         unique case (state_q)
            ANIM_IDLE: begin
               cnt_d   = '0;
               frame_d = '0;
               if (moving) state_d = ANIM_WALK;
            end
            ANIM_WALK: begin
               if (!moving) begin
                  state_d = ANIM_IDLE;
                  cnt_d   = '0;
                  frame_d = '0;
               end else if (dir_chg) begin
                  // A new facing restarts the step timer but keeps the pose.
                  cnt_d = '0;
               end else if (cnt_q == CW'(ANIM_DIV - 1)) begin
                  cnt_d   = '0;
                  frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ANIM_IDLE;
               cnt_d   = '0;
               frame_d = '0;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ANIM_IDLE;
         cnt_q   <= '0;
         frame_q <= '0;
         dir_q   <= DIR_DOWN;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         dir_q   <= dir_d;
      end
   end

   assign dir_out    = dir_q;
   assign anim_frame = frame_q;

endmodule

// File: rtl/link_sprite_fetch.sv
// Per-pixel player-sprite front end: box hit test, ROM addressing and the
// two-stage pipeline that hands a colour index to the palette lookup.
module link_sprite_fetch
   import zelda_sprite_pkg::*;
#(
   parameter int SPRITE_W = DEF_SPRITE_W,
   parameter int SPRITE_H = DEF_SPRITE_H,
   parameter int FRAMES   = 2,
   parameter int ANIM_DIV = 8,
   parameter int ADDR_W   = 11,
   parameter int FW       = clog2_min1(FRAMES)
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              frame_tick,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              pix_valid,
   input  logic [9:0]        sprite_x,
   input  logic [9:0]        sprite_y,
   input  logic [1:0]        dir,
   input  logic              moving,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_data,
   output logic [3:0]        pal_index,
   output logic              pix_hit,
   output logic [FW-1:0]     anim_frame
);

   dir_t        dir_q;
   logic [9:0]  sx_q, sx_d;
   logic [9:0]  sy_q, sy_d;
   logic        in_box_d_q, in_box_d_d;
   logic [3:0]  pal_index_q, pal_index_d;
   logic        pix_hit_q, pix_hit_d;

   logic        in_box;
   logic [10:0] x11, y11, sx11, sy11, dx, dy;

   sprite_anim_ctrl #(
      .FRAMES   (FRAMES),
      .ANIM_DIV (ANIM_DIV),
      .FW       (FW)
   ) u_anim (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .frame_tick (frame_tick),
      .dir_in     (dir),
      .moving     (moving),
      .dir_out    (dir_q),
      .anim_frame (anim_frame)
   );

   // 11-bit compare so a sprite near column 639 / row 479 clips instead of wrapping.
   always_comb begin
      x11  = {1'b0, DrawX};
      y11  = {1'b0, DrawY};
      sx11 = {1'b0, sx_q};
      sy11 = {1'b0, sy_q};
      dx   = x11 - sx11;
      dy   = y11 - sy11;
      // NOTE: Reset_n gates the hit so rom_addr reads 0 during reset without waiting for a clock.
      in_box = Reset_n && pix_valid
            && (x11 >= sx11) && (x11 < sx11 + 11'(SPRITE_W))
            && (y11 >= sy11) && (y11 < sy11 + 11'(SPRITE_H));
      rom_addr = '0;
      if (in_box) begin
         rom_addr = ADDR_W'((((32'(dir_q) * FRAMES + 32'(anim_frame)) * SPRITE_H
                              + 32'(dy)) * SPRITE_W) + 32'(dx));
      end
   end

   // Position latches only move on frame_tick; the pixel in that cycle still sees the old box.
   always_comb begin
      sx_d        = frame_tick ? sprite_x : sx_q;
      sy_d        = frame_tick ? sprite_y : sy_q;
      in_box_d_d  = in_box;
      pal_index_d = in_box_d_q ? rom_data : TRANSPARENT_IDX;
      pix_hit_d   = in_box_d_q && (rom_data != TRANSPARENT_IDX);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sx_q        <= '0;
         sy_q        <= '0;
         in_box_d_q  <= 1'b0;
         pal_index_q <= '0;
         pix_hit_q   <= 1'b0;
      end else begin
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         in_box_d_q  <= in_box_d_d;
         pal_index_q <= pal_index_d;
         pix_hit_q   <= pix_hit_d;
      end
   end

   assign pal_index = pal_index_q;
   assign pix_hit   = pix_hit_q;

endmodule

// File: tb/tb_link_sprite_fetch.sv
// Directed bench for link_sprite_fetch with a synchronous ROM model.
// ROM content: each word holds the low nibble of its address, except 1827 = 5.
module tb_link_sprite_fetch;

   logic        Clk;
   logic        Reset_n;
   logic        frame_tick;
   logic [9:0]  DrawX, DrawY;
   logic        pix_valid;
   logic [9:0]  sprite_x, sprite_y;
   logic [1:0]  dir;
   logic        moving;
   logic [10:0] rom_addr;
   logic [3:0]  rom_data;
   logic [3:0]  pal_index;
   logic        pix_hit;
   logic [0:0]  anim_frame;

   logic [3:0]  mem [0:2047];
   int          total;
   int          bad;

   link_sprite_fetch dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .frame_tick (frame_tick),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .pix_valid  (pix_valid),
      .sprite_x   (sprite_x),
      .sprite_y   (sprite_y),
      .dir        (dir),
      .moving     (moving),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .pal_index  (pal_index),
      .pix_hit    (pix_hit),
      .anim_frame (anim_frame)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) rom_data <= mem[rom_addr];

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_pix(input int x, input int y, input logic v);
      DrawX     = 10'(x);
      DrawY     = 10'(y);
      pix_valid = v;
      #1;
   endtask

   task automatic do_tick(input int x, input int y, input int d, input logic mv);
      sprite_x   = 10'(x);
      sprite_y   = 10'(y);
      dir        = 2'(d);
      moving     = mv;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      do_tick(100, 50, 0, 1'b1);
      set_pix(105, 50, 1'b1);
      step();
      step();
      total++;
      if (pal_index !== 4'd5) begin
         bad++;
         $display("FAIL pre_reset_pal got=%0d exp=5", pal_index);
      end
      #3;
      Reset_n = 1'b0;
      #1;
      total++;
      if (pal_index !== 4'd0 || pix_hit !== 1'b0 || anim_frame !== 1'b0 || rom_addr !== 11'd0) begin
         bad++;
         $display("FAIL reset_async got pal=%0d hit=%0b frame=%0d addr=%0d exp all 0",
                  pal_index, pix_hit, anim_frame, rom_addr);
      end
      #2;
      Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (pal_index !== 4'd0 || pix_hit !== 1'b0 || anim_frame !== 1'b0 || rom_addr !== 11'd0) begin
            bad++;
            $display("FAIL reset_hold[%0d] got pal=%0d hit=%0b frame=%0d addr=%0d exp all 0",
                     i, pal_index, pix_hit, anim_frame, rom_addr);
         end
      end
   endtask

   task automatic test_window();
      do_tick(100, 50, 0, 1'b0);
      set_pix(100, 50, 1'b1);
      total++;
      if (rom_addr !== 11'd0) begin
         bad++;
         $display("FAIL corner_tl_addr got=%0d exp=0", rom_addr);
      end
      step();
      step();
      total++;
      if (pal_index !== 4'd0 || pix_hit !== 1'b0) begin
         bad++;
         $display("FAIL corner_tl_transparent got pal=%0d hit=%0b exp 0/0", pal_index, pix_hit);
      end
   endtask

   task automatic test_back_to_back();
      int          px   [4] = '{115, 116, 100, 101};
      int          py   [4] = '{65, 65, 65, 50};
      logic [10:0] ea   [4] = '{11'd255, 11'd0, 11'd240, 11'd1};
      logic [3:0]  ep   [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
      logic        eh   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         if (i < 4) set_pix(px[i], py[i], 1'b1);
         else       set_pix(300, 300, 1'b1);
         if (i < 4) begin
            total++;
            if (rom_addr !== ea[i]) begin
               bad++;
               $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", i, rom_addr, ea[i]);
            end
         end
         if (i >= 2) begin
            total++;
            if (pal_index !== ep[i-2] || pix_hit !== eh[i-2]) begin
               bad++;
               $display("FAIL b2b_out[%0d] got pal=%0d hit=%0b exp pal=%0d hit=%0b",
                        i - 2, pal_index, pix_hit, ep[i-2], eh[i-2]);
            end
         end
         step();
      end
   endtask

   task automatic test_dir_frame();
      for (int k = 0; k < 9; k++) do_tick(100, 50, 3, 1'b1);
      total++;
      if (anim_frame !== 1'b1) begin
         bad++;
         $display("FAIL walk_setup_frame got=%0d exp=1", anim_frame);
      end
      set_pix(200, 200, 1'b1);
      step();
      step();
      set_pix(103, 52, 1'b1);
      total++;
      if (rom_addr !== 11'd1827) begin
         bad++;
         $display("FAIL right_f1_addr got=%0d exp=1827", rom_addr);
      end
      step();
      total++;
      if (pal_index !== 4'd0 || pix_hit !== 1'b0) begin
         bad++;
         $display("FAIL right_f1_early got pal=%0d hit=%0b exp 0/0", pal_index, pix_hit);
      end
      step();
      total++;
      if (pal_index !== 4'd5 || pix_hit !== 1'b1) begin
         bad++;
         $display("FAIL right_f1_out got pal=%0d hit=%0b exp 5/1", pal_index, pix_hit);
      end
   endtask

   task automatic test_transparent();
      set_pix(100, 51, 1'b1);
      total++;
      if (rom_addr !== 11'd1808) begin
         bad++;
         $display("FAIL zero_idx_addr got=%0d exp=1808", rom_addr);
      end
      step();
      step();
      total++;
      if (pal_index !== 4'd0 || pix_hit !== 1'b0) begin
         bad++;
         $display("FAIL zero_idx_out got pal=%0d hit=%0b exp 0/0", pal_index, pix_hit);
      end
      set_pix(103, 52, 1'b0);
      total++;
      if (rom_addr !== 11'd0) begin
         bad++;
         $display("FAIL invalid_addr got=%0d exp=0", rom_addr);
      end
      step();
      step();
      total++;
      if (pal_index !== 4'd0 || pix_hit !== 1'b0) begin
         bad++;
         $display("FAIL invalid_out got pal=%0d hit=%0b exp 0/0", pal_index, pix_hit);
      end
   endtask

   task automatic test_anim();
      logic exp_f;
      do_tick(100, 50, 3, 1'b0);
      total++;
      if (anim_frame !== 1'b0) begin
         bad++;
         $display("FAIL anim_stop got=%0d exp=0", anim_frame);
      end
      // Tick 1 enters WALK with counter 0; ticks 2..8 count to 7; tick 9 and 17 step the frame.
      for (int k = 1; k <= 20; k++) begin
         do_tick(100, 50, 3, 1'b1);
         exp_f = (k >= 9 && k <= 16);
         total++;
         if (anim_frame !== exp_f) begin
            bad++;
            $display("FAIL anim_walk[tick %0d] got=%0d exp=%0d", k, anim_frame, exp_f);
         end
      end
      do_tick(100, 50, 3, 1'b0);
      total++;
      if (anim_frame !== 1'b0) begin
         bad++;
         $display("FAIL anim_idle got=%0d exp=0", anim_frame);
      end
      for (int k = 1; k <= 8; k++) do_tick(100, 50, 3, 1'b1);
      do_tick(100, 50, 2, 1'b1);
      for (int k = 0; k < 7; k++) do_tick(100, 50, 2, 1'b1);
      total++;
      if (anim_frame !== 1'b0) begin
         bad++;
         $display("FAIL dir_restart_hold got=%0d exp=0", anim_frame);
      end
      do_tick(100, 50, 2, 1'b1);
      total++;
      if (anim_frame !== 1'b1) begin
         bad++;
         $display("FAIL dir_restart_step got=%0d exp=1", anim_frame);
      end
      do_tick(100, 50, 0, 1'b1);
      total++;
      if (anim_frame !== 1'b1) begin
         bad++;
         $display("FAIL dir_change_keep got=%0d exp=1", anim_frame);
      end
   endtask

   task automatic test_edge_clip();
      do_tick(630, 50, 0, 1'b0);
      set_pix(639, 50, 1'b1);
      total++;
      if (rom_addr !== 11'd9) begin
         bad++;
         $display("FAIL clip_col9_addr got=%0d exp=9", rom_addr);
      end
      step();
      step();
      total++;
      if (pal_index !== 4'd9 || pix_hit !== 1'b1) begin
         bad++;
         $display("FAIL clip_col9_out got pal=%0d hit=%0b exp 9/1", pal_index, pix_hit);
      end
      for (int x = 0; x <= 5; x++) begin
         set_pix(x, 50, 1'b1);
         step();
         step();
         total++;
         if (rom_addr !== 11'd0 || pix_hit !== 1'b0) begin
            bad++;
            $display("FAIL no_wrap[x=%0d] got addr=%0d hit=%0b exp 0/0", x, rom_addr, pix_hit);
         end
      end
      sprite_x = 10'd0;
      set_pix(639, 50, 1'b1);
      total++;
      if (rom_addr !== 11'd9) begin
         bad++;
         $display("FAIL midframe_ignore_old got=%0d exp=9", rom_addr);
      end
      set_pix(3, 50, 1'b1);
      total++;
      if (rom_addr !== 11'd0) begin
         bad++;
         $display("FAIL midframe_ignore_new got=%0d exp=0", rom_addr);
      end
      frame_tick = 1'b1;
      set_pix(639, 50, 1'b1);
      total++;
      if (rom_addr !== 11'd9) begin
         bad++;
         $display("FAIL tick_pixel_old_latch got=%0d exp=9", rom_addr);
      end
      step();
      frame_tick = 1'b0;
      set_pix(3, 50, 1'b1);
      total++;
      if (rom_addr !== 11'd3) begin
         bad++;
         $display("FAIL tick_reload got=%0d exp=3", rom_addr);
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      for (int i = 0; i < 2048; i++) mem[i] = 4'(i);
      mem[1827]  = 4'd5;
      Reset_n    = 1'b0;
      frame_tick = 1'b0;
      DrawX      = 10'd0;
      DrawY      = 10'd0;
      pix_valid  = 1'b0;
      sprite_x   = 10'd0;
      sprite_y   = 10'd0;
      dir        = 2'd0;
      moving     = 1'b0;
      repeat (3) step();
      Reset_n = 1'b1;
      step();

      test_reset();
      test_window();
      test_back_to_back();
      test_dir_frame();
      test_transparent();
      test_anim();
      test_edge_clip();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
